mul_issue_ctrl: RTL and testbench
=================================

Name: mul_issue_ctrl

Overview:
- Sequences the shared iterative multiplier behind the multiply reservation station.
- Captures 57-bit issue packets {valid, PC[31:0], Rd[7:0], op1_phys[7:0], op2_phys[7:0]} into a small skid FIFO; the station has no backpressure.
- Reads both source operands from the physical register file, then runs the shift-add multiplier core.
- Broadcasts the wakeup/writeback (MUL_result_valid/dest) consumed by every reservation station and the ROB.

Parameters:
- FIFO_DEPTH, 4, issue-packet skid buffer entries (power of 2, ≥2)
- STEP_BITS, 2, multiplier bits retired per EXEC cycle (1, 2 or 4); K = 32/STEP_BITS EXEC cycles

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- exception_sig  in  1  pipeline flush
- mret_sig  in  1  pipeline flush
- issue_in  in  57  RS packet; bit56 = valid, [55:24] PC, [23:16] Rd, [15:8] op1 phys, [7:0] op2 phys
- rf_raddr1  out  8  RF read address, operand 1
- rf_raddr2  out  8  RF read address, operand 2
- rf_rdata1  in  32  RF data, valid 1 cycle after address
- rf_rdata2  in  32  RF data, valid 1 cycle after address
- mul_fifo_afull  out  1  count ≥ FIFO_DEPTH-1; dispatch stalls mul issue
- mul_busy  out  1  state ≠ IDLE or FIFO non-empty
- MUL_result_valid  out  1  one-cycle result/wakeup strobe
- MUL_result_dest  out  8  destination physical register
- mul_result_data  out  32  product[31:0]
- mul_result_PC  out  32  PC of the completing op, for the ROB
- mul_overflow_err  out  1  sticky: a packet arrived while FIFO full
- perf_ops_done  out  32  optional counter
- perf_full_cycles  out  32  optional counter

Behaviour:
- Reset (async, reset_n=0): FIFO empty; state IDLE; all outputs 0, including mul_overflow_err and perf counters.
- Flush: exception_sig|mret_sig sampled at posedge, synchronous.
  - FIFO emptied; core aborted; state → IDLE.
  - MUL_result_valid is 0 in the cycle after flush and stays 0 until a new packet completes.
  - Flush beats a same-cycle issue_in valid; that packet is dropped.
  - mul_overflow_err is not cleared by flush.
- FIFO push: issue_in[56]=1 and not flushing.
  - If full and no pop in the same cycle: drop the packet and set mul_overflow_err.
  - Push and pop in the same cycle while full: both occur; count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, RD, EXEC, DONE.
  - IDLE: if FIFO non-empty, drive rf_raddr1/2 combinationally from the head op1/op2, pop, latch PC/Rd, go to RD. Otherwise rf_raddr = 0.
  - RD: load rf_rdata1 as multiplicand and rf_rdata2 as multiplier into the core; clear the step counter; go to EXEC.
  - EXEC: one STEP_BITS step per cycle; after K cycles go to DONE.
  - DONE: MUL_result_valid=1 with dest, data and PC for exactly one cycle.
    - FIFO non-empty: pop the head and drive its addresses this same cycle, go to RD (back-to-back, no IDLE bubble).
    - FIFO empty: go to IDLE.
  - Outside DONE, MUL_result_* are held at 0.
- Latency: packet valid at cycle t into an empty idle unit → MUL_result_valid at t+3+K (t+19 at default).
  - Back-to-back throughput: one result every K+2 cycles.
- Arithmetic: unsigned 32×32; only product[31:0] is kept (RV32 MUL; the low half is sign-agnostic).
- Reservation-station wakeup comparison of operands against MUL_result_dest is the stations' job, not this block's.

Optional Feature:
- MUL_PERF_EN
  - Defined: perf_ops_done increments on each MUL_result_valid. perf_full_cycles increments on each cycle the FIFO is full. Both wrap at 2^32; neither is cleared by flush.
  - Undefined: both ports tied to 0 and no counter flops are built.

Decomposition:
- mul_pkg holds:
  - state enum {IDLE, RD, EXEC, DONE}
  - packet field constants: PKT_VALID=56, PKT_PC_HI/LO=55/24, PKT_RD_HI/LO=23/16, PKT_OP1_HI/LO=15/8, PKT_OP2_HI/LO=7/0
  - PHY_W=8, XLEN=32
- Sub-module mul_iter_core(STEP_BITS):
  - inputs: load, step, abort, a, b
  - output: prod_lo[31:0]
  - shift-add accumulator; the controller owns counter and FSM.

Test Plan:
- Single op: op1 phys 5=7, op2 phys 9=6, Rd=12, PC=0x100 at t=0 → MUL_result_valid at t=19, dest=12, data=42, PC=0x100; rf_raddr 5/9 at t=1.
- Wrap: 0xFFFFFFFF × 2 → data 0xFFFFFFFE; 0x10000 × 0x10000 → data 0.
- Back-to-back: 3 packets on consecutive cycles → results at t=19, 37, 55; mul_fifo_afull=1 while count ≥ 3; no overflow.
- Overflow: 6 packets on consecutive cycles, depth 4 → packet 6 dropped, mul_overflow_err=1, 5 results produced.
- Flush mid-EXEC: exception_sig at t=10 with 2 queued → no MUL_result_valid ever; mul_busy=0 at t=11; a same-cycle issue_in is also dropped.
- Async reset mid-EXEC: reset_n low between edges → all outputs 0 immediately; next packet completes normally with 19-cycle latency.

Source files
------------

// File: rtl/mul_pkg.sv
// ---------------------------------------------------------------------------
// mul_pkg
// Shared types and constants for the multiply issue controller:
//   - FSM state enum (IDLE, RD, EXEC, DONE)
//   - bit positions of the fields in the 57-bit issue packet
//   - the packed form of a buffered packet and an unpack helper
// ---------------------------------------------------------------------------
package mul_pkg;

  localparam int XLEN  = 32;
  localparam int PHY_W = 8;
  localparam int PKT_W = 57;

  localparam int PKT_VALID  = 56;
  localparam int PKT_PC_HI  = 55;
  localparam int PKT_PC_LO  = 24;
  localparam int PKT_RD_HI  = 23;
  localparam int PKT_RD_LO  = 16;
  localparam int PKT_OP1_HI = 15;
  localparam int PKT_OP1_LO = 8;
  localparam int PKT_OP2_HI = 7;
  localparam int PKT_OP2_LO = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    EXEC = 2'd2,
    DONE = 2'd3
  } mul_state_e;

  // Buffered packet: the valid bit is consumed at push time and not stored.
  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [PHY_W-1:0] rd;
    logic [PHY_W-1:0] op1;
    logic [PHY_W-1:0] op2;
  } mul_pkt_t;

  function automatic mul_pkt_t pkt_unpack(input logic [PKT_W-1:0] raw);
    mul_pkt_t p;
    p.pc  = raw[PKT_PC_HI:PKT_PC_LO];
    p.rd  = raw[PKT_RD_HI:PKT_RD_LO];
    p.op1 = raw[PKT_OP1_HI:PKT_OP1_LO];
    p.op2 = raw[PKT_OP2_HI:PKT_OP2_LO];
    return p;
  endfunction

endpackage

// File: rtl/mul_iter_core.sv
// ---------------------------------------------------------------------------
// mul_iter_core
// Shift-add multiplier datapath retiring STEP_BITS multiplier bits per step.
// Only the low XLEN bits of the product are accumulated. Step counting and
// sequencing belong to the controller.
// Ports:
//   clk      clock
//   load     capture a (multiplicand) and b (multiplier), clear accumulator
//   step     add the partial product for the low STEP_BITS of the multiplier
//   abort    clear the accumulator (pipeline flush)
//   a, b     operands
//   prod_lo  running product[31:0]; final after 32/STEP_BITS steps
// ---------------------------------------------------------------------------
module mul_iter_core
  import mul_pkg::*;
#(
  parameter int STEP_BITS = 2
) (
  input  logic            clk,
  input  logic            load,
  input  logic            step,
  input  logic            abort,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] prod_lo
);

  logic [XLEN-1:0] r_acc;
  logic [XLEN-1:0] r_mcand;
  logic [XLEN-1:0] r_mplier;

  // Sum of the shifted multiplicand copies selected by the current digit;
  // bits shifted past XLEN cannot affect product[31:0] and are dropped.
  function automatic logic [XLEN-1:0] partial_sum(input logic [XLEN-1:0]      mc,
                                                  input logic [STEP_BITS-1:0] digit);
    logic [XLEN-1:0] s;
    s = '0;
    for (int j = 0; j < STEP_BITS; j++) begin
      if (digit[j]) s = s + (mc << j);
    end
    return s;
  endfunction

  // Datapath only: no reset, state is (re)established by load.
  always_ff @(posedge clk) begin
    if (abort) begin
      r_acc <= '0;
    end else if (load) begin
      r_acc    <= '0;
      r_mcand  <= a;
      r_mplier <= b;
    end else if (step) begin
      r_acc    <= r_acc + partial_sum(r_mcand, r_mplier[STEP_BITS-1:0]);
      r_mcand  <= r_mcand << STEP_BITS;
      r_mplier <= r_mplier >> STEP_BITS;
    end
  end

  assign prod_lo = r_acc;

endmodule

// File: rtl/mul_issue_ctrl.sv
// ---------------------------------------------------------------------------
// mul_issue_ctrl
// Sequences the shared iterative multiplier behind the multiply reservation
// station: buffers issue packets in a skid FIFO, reads both operands from
// the physical register file, runs mul_iter_core for K = 32/STEP_BITS
// cycles and broadcasts a one-cycle result/wakeup strobe.
// Optional feature macro: MUL_PERF_EN (builds perf_ops_done and
// perf_full_cycles counters; otherwise both ports are tied to 0).
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   exception_sig, mret_sig synchronous pipeline flush
//   issue_in[56:0]          {valid, PC, Rd, op1 phys, op2 phys}
//   rf_raddr1/2             RF read addresses (driven while popping)
//   rf_rdata1/2             RF data, one cycle after the address
//   mul_fifo_afull          FIFO count >= FIFO_DEPTH-1
//   mul_busy                FSM not idle or FIFO non-empty
//   MUL_result_valid/dest   one-cycle wakeup/writeback strobe
//   mul_result_data/PC      product[31:0] and PC of the completing op
//   mul_overflow_err        sticky: packet dropped on a full FIFO
//   perf_ops_done           completed operations (MUL_PERF_EN)
//   perf_full_cycles        cycles with the FIFO full (MUL_PERF_EN)
// ---------------------------------------------------------------------------
module mul_issue_ctrl
  import mul_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int STEP_BITS  = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              exception_sig,
  input  logic              mret_sig,
  input  logic [PKT_W-1:0]  issue_in,
  output logic [PHY_W-1:0]  rf_raddr1,
  output logic [PHY_W-1:0]  rf_raddr2,
  input  logic [XLEN-1:0]   rf_rdata1,
  input  logic [XLEN-1:0]   rf_rdata2,
  output logic              mul_fifo_afull,
  output logic              mul_busy,
  output logic              MUL_result_valid,
  output logic [PHY_W-1:0]  MUL_result_dest,
  output logic [XLEN-1:0]   mul_result_data,
  output logic [XLEN-1:0]   mul_result_PC,
  output logic              mul_overflow_err,
  output logic [31:0]       perf_ops_done,
  output logic [31:0]       perf_full_cycles
);

  localparam int K     = XLEN / STEP_BITS;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(K);

  localparam logic [PTR_W:0]   CNT_FULL  = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   CNT_AFULL = (PTR_W+1)'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(K - 1);

  mul_state_e       r_state;
  mul_state_e       w_state_nxt;

  mul_pkt_t         r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W:0]   r_count;
  logic [CNT_W-1:0] r_step_cnt;
  logic [XLEN-1:0]  r_pc;
  logic [PHY_W-1:0] r_rd;

  logic             w_flush;
  logic             w_empty;
  logic             w_full;
  logic             w_rd_sel;
  logic             w_pop;
  logic             w_push_req;
  logic             w_push;
  logic             w_load;
  logic             w_step;
  logic             w_core_load;
  logic             w_core_step;
  logic [XLEN-1:0]  w_prod;
  mul_pkt_t         w_head;

  assign w_flush    = exception_sig | mret_sig;
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CNT_FULL);
  assign w_head     = r_mem[r_rptr];
  // Head selection (and its RF addresses) does not depend on flush; only
  // the actual pop is suppressed by it.
  assign w_pop      = w_rd_sel & ~w_flush;
  assign w_push_req = issue_in[PKT_VALID] & ~w_flush;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push     = w_push_req & (~w_full | w_pop);

  assign mul_fifo_afull = (r_count >= CNT_AFULL);
  assign mul_busy       = (r_state != IDLE) | ~w_empty;

  // ---- FIFO control ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr           <= '0;
      r_rptr           <= '0;
      r_count          <= '0;
      mul_overflow_err <= 1'b0;
    end else begin
      if (w_push_req && w_full && !w_pop) mul_overflow_err <= 1'b1;
      if (w_flush) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + 1'b1;
        if (w_pop)  r_rptr <= r_rptr + 1'b1;
        unique case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: ;
        endcase
      end
    end
  end

  // ---- FIFO storage and in-flight op tags (datapath, no reset) ----
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= pkt_unpack(issue_in);
    if (w_pop) begin
      r_pc <= w_head.pc;
      r_rd <= w_head.rd;
    end
  end

  // ---- FSM state register and step counter ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_step_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == RD)        r_step_cnt <= '0;
      else if (r_state == EXEC) r_step_cnt <= r_step_cnt + 1'b1;
    end
  end

  // ---- FSM next state ----
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_pop) w_state_nxt = RD;
      RD:      w_state_nxt = EXEC;
      EXEC:    if (r_step_cnt == STEP_LAST) w_state_nxt = DONE;
      DONE:    w_state_nxt = w_pop ? RD : IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (w_flush) w_state_nxt = IDLE;
  end

  // ---- FSM outputs ----
  always_comb begin
    w_rd_sel         = 1'b0;
    w_load           = 1'b0;
    w_step           = 1'b0;
    rf_raddr1        = '0;
    rf_raddr2        = '0;
    MUL_result_valid = 1'b0;
    MUL_result_dest  = '0;
    mul_result_data  = '0;
    mul_result_PC    = '0;
    unique case (r_state)
      IDLE: w_rd_sel = ~w_empty;
      RD:   w_load   = 1'b1;
      EXEC: w_step   = 1'b1;
      DONE: begin
        // Next op is started in the completion cycle to avoid an IDLE bubble.
        w_rd_sel         = ~w_empty;
        MUL_result_valid = 1'b1;
        MUL_result_dest  = r_rd;
        mul_result_data  = w_prod;
        mul_result_PC    = r_pc;
      end
      default: ;
    endcase
    if (w_rd_sel) begin
      rf_raddr1 = w_head.op1;
      rf_raddr2 = w_head.op2;
    end
  end

  assign w_core_load = w_load & ~w_flush;
  assign w_core_step = w_step & ~w_flush;

  mul_iter_core #(
    .STEP_BITS (STEP_BITS)
  ) u_core (
    .clk     (clk),
    .load    (w_core_load),
    .step    (w_core_step),
    .abort   (w_flush),
    .a       (rf_rdata1),
    .b       (rf_rdata2),
    .prod_lo (w_prod)
  );

`ifdef MUL_PERF_EN
  logic [31:0] r_perf_ops;
  logic [31:0] r_perf_full;

  // Free-running, wrap at 2^32; flush does not clear them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_perf_ops  <= '0;
      r_perf_full <= '0;
    end else begin
      if (MUL_result_valid) r_perf_ops  <= r_perf_ops + 32'd1;
      if (w_full)           r_perf_full <= r_perf_full + 32'd1;
    end
  end

  assign perf_ops_done    = r_perf_ops;
  assign perf_full_cycles = r_perf_full;
`else
  assign perf_ops_done    = '0;
  assign perf_full_cycles = '0;
`endif

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mul_issue_ctrl
// Directed and randomized stimulus for mul_issue_ctrl, checked every cycle
// against a transaction-level reference (packet queue plus a scheduled
// completion cycle per operation), with extra directed latency/data checks.
// ---------------------------------------------------------------------------
module tb_mul_issue_ctrl;

  localparam int DEPTH = 4;
  localparam int SB    = 2;
  localparam int K     = 32 / SB;
  localparam int LAT   = 3 + K;

  logic        clk;
  logic        reset_n;
  logic        exception_sig;
  logic        mret_sig;
  logic [56:0] issue_in;
  logic [7:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        mul_fifo_afull, mul_busy, MUL_result_valid, mul_overflow_err;
  logic [7:0]  MUL_result_dest;
  logic [31:0] mul_result_data, mul_result_PC, perf_ops_done, perf_full_cycles;

  mul_issue_ctrl #(.FIFO_DEPTH(DEPTH), .STEP_BITS(SB)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .exception_sig    (exception_sig),
    .mret_sig         (mret_sig),
    .issue_in         (issue_in),
    .rf_raddr1        (rf_raddr1),
    .rf_raddr2        (rf_raddr2),
    .rf_rdata1        (rf_rdata1),
    .rf_rdata2        (rf_rdata2),
    .mul_fifo_afull   (mul_fifo_afull),
    .mul_busy         (mul_busy),
    .MUL_result_valid (MUL_result_valid),
    .MUL_result_dest  (MUL_result_dest),
    .mul_result_data  (mul_result_data),
    .mul_result_PC    (mul_result_PC),
    .mul_overflow_err (mul_overflow_err),
    .perf_ops_done    (perf_ops_done),
    .perf_full_cycles (perf_full_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: synchronous read, data one cycle after the address.
  logic [31:0] regs [256];
  always @(posedge clk) begin
    rf_rdata1 <= regs[rf_raddr1];
    rf_rdata2 <= regs[rf_raddr2];
  end

  // ---- reference model ----
  typedef struct {
    logic [31:0] pc;
    logic [7:0]  rd;
    logic [7:0]  op1;
    logic [7:0]  op2;
  } pkt_t;

  pkt_t        mq[$];
  pkt_t        m_cur;
  logic [31:0] m_prod;
  bit          m_inflight;
  int          m_done_at;
  bit          m_ovf;
  logic [31:0] m_ops;
  logic [31:0] m_full;
  int          cyc;

  int n_tests;
  int n_fail;

  function automatic pkt_t to_pkt(input logic [56:0] raw);
    pkt_t p;
    p.pc  = raw[55:24];
    p.rd  = raw[23:16];
    p.op1 = raw[15:8];
    p.op2 = raw[7:0];
    return p;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_inflight = 0;
    m_ovf      = 0;
    m_ops      = '0;
    m_full     = '0;
  endtask

  // Advance the model over one clock edge using the inputs present at it.
  task automatic model_step();
    bit sel, vld_now, full_pre;
    if (!reset_n) begin
      model_reset();
    end else begin
      sel      = (mq.size() > 0) && (!m_inflight || m_done_at == cyc);
      vld_now  = m_inflight && (m_done_at == cyc);
      full_pre = (mq.size() == DEPTH);
      if (vld_now)  m_ops  = m_ops + 32'd1;
      if (full_pre) m_full = m_full + 32'd1;
      if (exception_sig || mret_sig) begin
        mq.delete();
        m_inflight = 0;
      end else begin
        if (vld_now) m_inflight = 0;
        if (sel) begin
          m_cur      = mq.pop_front();
          m_prod     = regs[m_cur.op1] * regs[m_cur.op2];
          m_inflight = 1;
          m_done_at  = cyc + K + 2;
        end
        if (issue_in[56]) begin
          if (full_pre && !sel) m_ovf = 1;
          else mq.push_back(to_pkt(issue_in));
        end
      end
    end
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    bit e_vld, e_sel;
    e_vld = m_inflight && (m_done_at == cyc);
    e_sel = (mq.size() > 0) && (!m_inflight || m_done_at == cyc);
    chk("result_valid", 32'(MUL_result_valid), 32'(e_vld));
    chk("result_dest",  32'(MUL_result_dest),  e_vld ? 32'(m_cur.rd) : 32'd0);
    chk("result_data",  mul_result_data,       e_vld ? m_prod : 32'd0);
    chk("result_pc",    mul_result_PC,         e_vld ? m_cur.pc : 32'd0);
    chk("raddr1",       32'(rf_raddr1),        e_sel ? 32'(mq[0].op1) : 32'd0);
    chk("raddr2",       32'(rf_raddr2),        e_sel ? 32'(mq[0].op2) : 32'd0);
    chk("afull",        32'(mul_fifo_afull),   32'(mq.size() >= DEPTH - 1));
    chk("busy",         32'(mul_busy),         32'(m_inflight || mq.size() > 0));
    chk("overflow",     32'(mul_overflow_err), 32'(m_ovf));
`ifdef MUL_PERF_EN
    chk("perf_ops",     perf_ops_done,         m_ops);
    chk("perf_full",    perf_full_cycles,      m_full);
`else
    chk("perf_ops",     perf_ops_done,         32'd0);
    chk("perf_full",    perf_full_cycles,      32'd0);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  function automatic logic [56:0] mk_pkt(input logic [31:0] pc, input logic [7:0] rd,
                                         input logic [7:0] o1, input logic [7:0] o2);
    return {1'b1, pc, rd, o1, o2};
  endfunction

  // Issue one packet into an idle unit and check latency and result.
  task automatic run_single(input string tag, input logic [31:0] pc, input logic [7:0] rd,
                            input logic [7:0] o1, input logic [7:0] o2,
                            input logic [31:0] exp_data);
    int  lat;
    bit  seen;
    logic [31:0] d, p, r;
    lat = 0; seen = 0; d = '0; p = '0; r = '0;
    issue_in = mk_pkt(pc, rd, o1, o2);
    for (int i = 1; i <= 40 && !seen; i++) begin
      tick();
      issue_in = '0;
      if (i == 1) begin
        chk({tag, "_raddr1_t1"}, 32'(rf_raddr1), 32'(o1));
        chk({tag, "_raddr2_t1"}, 32'(rf_raddr2), 32'(o2));
      end
      if (MUL_result_valid) begin
        seen = 1; lat = i;
        d = mul_result_data; p = mul_result_PC; r = 32'(MUL_result_dest);
      end
    end
    chk({tag, "_latency"}, 32'(lat), 32'(LAT));
    chk({tag, "_data"}, d, exp_data);
    chk({tag, "_pc"},   p, pc);
    chk({tag, "_dest"}, r, 32'(rd));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int res_t[$];
    int nres;
    bit busy_after;

    n_tests = 0; n_fail = 0; cyc = 0;
    reset_n = 1'b0; exception_sig = 1'b0; mret_sig = 1'b0; issue_in = '0;
    for (int i = 0; i < 256; i++) regs[i] = $urandom;
    model_reset();

    // Reset state
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // Single op and wrap cases
    regs[5] = 32'd7; regs[9] = 32'd6;
    run_single("single", 32'h100, 8'd12, 8'd5, 8'd9, 32'd42);
    regs[20] = 32'hFFFF_FFFF; regs[21] = 32'd2;
    run_single("wrap_ff", 32'h204, 8'd33, 8'd20, 8'd21, 32'hFFFF_FFFE);
    regs[22] = 32'h0001_0000; regs[23] = 32'h0001_0000;
    run_single("wrap_zero", 32'h308, 8'd44, 8'd22, 8'd23, 32'd0);

    // Back-to-back: three packets on consecutive cycles
    res_t.delete();
    for (int k = 1; k <= 60; k++) begin
      issue_in = (k <= 3) ? mk_pkt(32'h400 + 32'(k * 4), 8'(50 + k), 8'(60 + k), 8'(70 + k)) : '0;
      tick();
      if (MUL_result_valid) res_t.push_back(k);
    end
    issue_in = '0;
    chk("b2b_count", 32'(res_t.size()), 32'd3);
    chk("b2b_t0", (res_t.size() > 0) ? 32'(res_t[0]) : 32'd0, 32'd19);
    chk("b2b_t1", (res_t.size() > 1) ? 32'(res_t[1]) : 32'd0, 32'd37);
    chk("b2b_t2", (res_t.size() > 2) ? 32'(res_t[2]) : 32'd0, 32'd55);
    chk("b2b_no_ovf", 32'(mul_overflow_err), 32'd0);

    // Flush mid-EXEC with two queued, plus a same-cycle issue
    nres = 0;
    for (int k = 1; k <= 10; k++) begin
      issue_in = (k <= 3) ? mk_pkt(32'h500 + 32'(k), 8'(80 + k), 8'(90 + k), 8'(100 + k)) : '0;
      tick();
    end
    exception_sig = 1'b1;
    issue_in = mk_pkt(32'h5FF, 8'd99, 8'd1, 8'd2);
    tick();
    exception_sig = 1'b0;
    issue_in = '0;
    busy_after = mul_busy;
    chk("flush_busy_t11", 32'(busy_after), 32'd0);
    for (int k = 0; k < 60; k++) begin
      tick();
      if (MUL_result_valid) nres++;
    end
    chk("flush_no_result", 32'(nres), 32'd0);

    // Overflow: six packets on consecutive cycles into a depth-4 FIFO
    nres = 0;
    for (int k = 1; k <= 130; k++) begin
      issue_in = (k <= 6) ? mk_pkt(32'h600 + 32'(k), 8'(110 + k), 8'(120 + k), 8'(130 + k)) : '0;
      tick();
      if (MUL_result_valid) nres++;
    end
    issue_in = '0;
    chk("ovf_results", 32'(nres), 32'd5);
    chk("ovf_sticky", 32'(mul_overflow_err), 32'd1);

    // Async reset mid-EXEC, then a normal op
    issue_in = mk_pkt(32'h700, 8'd7, 8'd5, 8'd9);
    tick();
    issue_in = '0;
    repeat (7) tick();
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("areset_valid", 32'(MUL_result_valid), 32'd0);
    chk("areset_busy",  32'(mul_busy), 32'd0);
    chk("areset_ovf",   32'(mul_overflow_err), 32'd0);
    #1;
    reset_n = 1'b1;
    run_single("post_reset", 32'h800, 8'd13, 8'd5, 8'd9, 32'd42);

    // Randomized traffic with occasional flushes
    nres = 0;
    for (int k = 0; k < 600; k++) begin
      issue_in      = {1'($urandom_range(0, 4) < 2), 32'($urandom), 8'($urandom),
                       8'($urandom), 8'($urandom)};
      exception_sig = ($urandom_range(0, 99) == 0);
      mret_sig      = ($urandom_range(0, 99) == 0);
      tick();
      if (MUL_result_valid) nres++;
    end
    issue_in = '0; exception_sig = 1'b0; mret_sig = 1'b0;
    for (int k = 0; k < 120; k++) begin
      tick();
      if (MUL_result_valid) nres++;
    end
    chk("rand_drained_busy", 32'(mul_busy), 32'd0);
    chk("rand_some_results", 32'(nres > 0), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
